// File: rtl/bk_add_pkg.sv
// Shared definitions for the Brent-Kung adder arbiter: state encoding, defaults, id-width helper.
package bk_add_pkg;

   localparam int DEF_N = 4;
   localparam int DEF_W = 64;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      CALC = ST_CALC,
      RESP = ST_RESP
   } state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/bk_add_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping at N.
module rr_pick
   import bk_add_pkg::*;
#(
   parameter int N = DEF_N
) (
   input  logic [N-1:0]          req,
   input  logic [clog2(N)-1:0]   ptr,
   output logic [N-1:0]          gnt_oh,
   output logic [clog2(N)-1:0]   gnt_idx,
   output logic                  any
);

   localparam int IW = clog2(N);

   always_comb begin
      int j;
      j       = 0;
      gnt_oh  = '0;
      gnt_idx = '0;
      any     = 1'b0;
      for (int k = 0; k < N; k++) begin
         j = (int'(ptr) + k) % N;
         if (!any && req[j]) begin
            any        = 1'b1;
            gnt_idx    = IW'(j);
            gnt_oh[j]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bk_add_arbiter.sv
// Round-robin sharing of one Brent-Kung adder between N requesters, one operation in flight.
// Optional per-requester grant counters are built when BKA_ARB_STATS_EN is defined.
module bk_add_arbiter
   import bk_add_pkg::*;
#(
   parameter int N     = DEF_N,
   parameter int W     = DEF_W,
   parameter int CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N-1:0]          req_valid,
   output logic [N-1:0]          req_ready,
   input  logic [N*W-1:0]        req_a,
   input  logic [N*W-1:0]        req_b,
   output logic [N-1:0]          rsp_valid,
   input  logic [N-1:0]          rsp_ready,
   output logic [W:0]            rsp_sum,
   output logic [clog2(N)-1:0]   rsp_id
`ifdef BKA_ARB_STATS_EN
   ,
   output logic [N*CNT_W-1:0]    grant_cnt
`endif
);

   localparam int IW = clog2(N);

   if (N < 2 || N > 8 || W < 16 || (W & (W - 1)) != 0 || CNT_W < 1) begin : g_bad_param
      $error("bk_add_arbiter: unsupported parameter set");
   end

   state_t          state;
   logic [IW-1:0]   rr_ptr;
   logic [W-1:0]    op_a;
   logic [W-1:0]    op_b;

   logic [N-1:0]    gnt_oh;
   logic [IW-1:0]   gnt_idx;
   logic            any;
   logic [IW-1:0]   ptr_nxt;
   logic            owner_take;
   logic            slot_free;
   logic [N-1:0]    owner_oh;

   rr_pick #(.N(N)) u_pick (
      .req     (req_valid),
      .ptr     (rr_ptr),
      .gnt_oh  (gnt_oh),
      .gnt_idx (gnt_idx),
      .any     (any)
   );

   // A new grant is possible when idle, or in the very cycle the owner takes its result.
   assign owner_take = (state == RESP) && rsp_ready[rsp_id];
   assign slot_free  = (state == IDLE) || owner_take;
   assign req_ready  = (slot_free && any) ? gnt_oh : '0;
   assign ptr_nxt    = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
   assign owner_oh   = N'(1) << rsp_id;

   // Brent-Kung prefix carry network, fed only from the operand registers.
   logic [W-1:0] prop;
   logic [W-1:0] gen_pre;
   logic [W-1:0] prop_pre;
   logic [W:0]   add_sum;

   always_comb begin
      prop     = op_a ^ op_b;
      gen_pre  = op_a & op_b;
      prop_pre = prop;
      for (int d = 1; d < W; d = d * 2) begin
         for (int i = 2 * d - 1; i < W; i = i + 2 * d) begin
            gen_pre[i]  = gen_pre[i] | (prop_pre[i] & gen_pre[i-d]);
            prop_pre[i] = prop_pre[i] & prop_pre[i-d];
         end
      end
      for (int d = W / 4; d >= 1; d = d / 2) begin
         for (int i = 3 * d - 1; i < W; i = i + 2 * d) begin
            gen_pre[i]  = gen_pre[i] | (prop_pre[i] & gen_pre[i-d]);
            prop_pre[i] = prop_pre[i] & prop_pre[i-d];
         end
      end
      add_sum = {gen_pre[W-1], prop ^ {gen_pre[W-2:0], 1'b0}};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         op_a      <= '0;
         op_b      <= '0;
         rsp_valid <= '0;
         rsp_sum   <= '0;
         rsp_id    <= '0;
      end else begin
         if (slot_free && any) begin
            op_a   <= req_a[gnt_idx*W +: W];
            op_b   <= req_b[gnt_idx*W +: W];
            rsp_id <= gnt_idx;
            rr_ptr <= ptr_nxt;
         end
         case (state)
            IDLE: begin
               if (any) state <= CALC;
            end
            CALC: begin
               rsp_sum   <= add_sum;
               rsp_valid <= owner_oh;
               state     <= RESP;
            end
            RESP: begin
               if (owner_take) begin
                  rsp_valid <= '0;
                  state     <= any ? CALC : IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef BKA_ARB_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_cnt <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i] &&
                grant_cnt[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})
               grant_cnt[i*CNT_W +: CNT_W] <= grant_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_bk_add_arbiter.sv
// Self-checking bench for bk_add_arbiter: directed scenarios plus a randomized run against a cycle-level model.
module tb_bk_add_arbiter;

   localparam int N     = 4;
   localparam int W     = 64;
   localparam int CNT_W = 16;
   localparam int IW    = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_ready;
   logic [N*W-1:0]    req_a;
   logic [N*W-1:0]    req_b;
   logic [N-1:0]      rsp_valid;
   logic [N-1:0]      rsp_ready;
   logic [W:0]        rsp_sum;
   logic [IW-1:0]     rsp_id;
`ifdef BKA_ARB_STATS_EN
   logic [N*CNT_W-1:0] grant_cnt;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   logic [W:0] exp_q[$];

   bk_add_arbiter #(.N(N), .W(W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_sum   (rsp_sum),
      .rsp_id    (rsp_id)
`ifdef BKA_ARB_STATS_EN
      ,
      .grant_cnt (grant_cnt)
`endif
   );

   always #5 clk = ~clk;

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = '0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      req_valid[i]    = 1'b1;
      req_a[i*W +: W] = a;
      req_b[i*W +: W] = b;
   endtask

   function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b);
      return {1'b0, a} + {1'b0, b};
   endfunction

   // ---------------- scenarios ----------------
   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      step();
      #1;
      n_cmp++; if (rsp_valid !== '0) begin n_bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
      n_cmp++; if (rsp_sum !== '0) begin n_bad++; $display("FAIL reset_rsp_sum got=%h exp=0", rsp_sum); end
      n_cmp++; if (rsp_id !== '0) begin n_bad++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
      n_cmp++; if (req_ready !== '0) begin n_bad++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
      step();
      rst = 1'b0;
   endtask

   task automatic test_single();
      set_req(0, 64'd5, 64'd7);
      rsp_ready = '1;
      #1;
      n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
      step();
      req_valid = '0;
      #1;
      n_cmp++; if (rsp_valid !== '0) begin n_bad++; $display("FAIL single_early_valid got=%b exp=0000", rsp_valid); end
      step();
      #1;
      n_cmp++; if (rsp_valid !== 4'b0001) begin n_bad++; $display("FAIL single_valid got=%b exp=0001", rsp_valid); end
      n_cmp++; if (rsp_sum !== 65'd12) begin n_bad++; $display("FAIL single_sum got=%0d exp=12", rsp_sum); end
      n_cmp++; if (rsp_id !== 2'd0) begin n_bad++; $display("FAIL single_id got=%0d exp=0", rsp_id); end
      step();
      #1;
      n_cmp++; if (rsp_valid !== '0) begin n_bad++; $display("FAIL single_retire got=%b exp=0000", rsp_valid); end
   endtask

   task automatic test_carry();
      logic [W:0] exp_sum;
      exp_sum = 65'h1_FFFF_FFFF_FFFF_FFFE;
      set_req(1, '1, '1);
      rsp_ready = '1;
      #1;
      n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL carry_ready got=%b exp=0010", req_ready); end
      step();
      req_valid = '0;
      step();
      #1;
      n_cmp++; if (rsp_sum !== exp_sum) begin n_bad++; $display("FAIL carry_sum got=%h exp=%h", rsp_sum, exp_sum); end
      n_cmp++; if (rsp_id !== 2'd1) begin n_bad++; $display("FAIL carry_id got=%0d exp=1", rsp_id); end
      step();
   endtask

   task automatic test_fairness();
      logic [W-1:0] fa[N];
      logic [W-1:0] fb[N];
      logic [N-1:0] exp_v;
      int j;
      apply_reset();
      for (int i = 0; i < N; i++) begin
         fa[i] = {$urandom, $urandom};
         fb[i] = {$urandom, $urandom};
         set_req(i, fa[i], fb[i]);
      end
      rsp_ready = '1;
      for (int k = 0; k <= 16; k++) begin
         if (k == 15) req_valid = '0;
         #1;
         exp_v = '0;
         if (k % 2 == 0 && k < 15) exp_v[(k / 2) % N] = 1'b1;
         n_cmp++; if (req_ready !== exp_v) begin n_bad++; $display("FAIL fair_ready k=%0d got=%b exp=%b", k, req_ready, exp_v); end
         if (k >= 2 && k % 2 == 0) begin
            j = ((k / 2) - 1) % N;
            exp_v = '0;
            exp_v[j] = 1'b1;
            n_cmp++; if (rsp_valid !== exp_v) begin n_bad++; $display("FAIL fair_valid k=%0d got=%b exp=%b", k, rsp_valid, exp_v); end
            n_cmp++; if (rsp_sum !== ref_sum(fa[j], fb[j])) begin n_bad++; $display("FAIL fair_sum k=%0d got=%h exp=%h", k, rsp_sum, ref_sum(fa[j], fb[j])); end
         end
         step();
      end
      #1;
      n_cmp++; if (rsp_valid !== '0) begin n_bad++; $display("FAIL fair_idle got=%b exp=0000", rsp_valid); end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] a2, b2, a3, b3;
      a2 = {$urandom, $urandom}; b2 = {$urandom, $urandom};
      a3 = {$urandom, $urandom}; b3 = {$urandom, $urandom};
      idle_inputs();
      set_req(2, a2, b2);
      #1;
      n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL bp_grant got=%b exp=0100", req_ready); end
      step();
      req_valid = '0;
      set_req(3, a3, b3);
      rsp_ready = 4'b1011;
      step();
      for (int k = 0; k < 5; k++) begin
         #1;
         n_cmp++; if (rsp_valid !== 4'b0100) begin n_bad++; $display("FAIL bp_valid k=%0d got=%b exp=0100", k, rsp_valid); end
         n_cmp++; if (rsp_sum !== ref_sum(a2, b2)) begin n_bad++; $display("FAIL bp_sum k=%0d got=%h exp=%h", k, rsp_sum, ref_sum(a2, b2)); end
         n_cmp++; if (rsp_id !== 2'd2) begin n_bad++; $display("FAIL bp_id k=%0d got=%0d exp=2", k, rsp_id); end
         n_cmp++; if (req_ready !== '0) begin n_bad++; $display("FAIL bp_ready k=%0d got=%b exp=0000", k, req_ready); end
         step();
      end
      rsp_ready = 4'b0100;
      #1;
      n_cmp++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL bp_b2b_grant got=%b exp=1000", req_ready); end
      step();
      req_valid = '0;
      rsp_ready = '1;
      #1;
      n_cmp++; if (rsp_valid !== '0) begin n_bad++; $display("FAIL bp_calc_valid got=%b exp=0000", rsp_valid); end
      step();
      #1;
      n_cmp++; if (rsp_valid !== 4'b1000) begin n_bad++; $display("FAIL bp_next_valid got=%b exp=1000", rsp_valid); end
      n_cmp++; if (rsp_sum !== ref_sum(a3, b3)) begin n_bad++; $display("FAIL bp_next_sum got=%h exp=%h", rsp_sum, ref_sum(a3, b3)); end
      step();
   endtask

   task automatic test_reset_mid_op();
      logic [W-1:0] a, b;
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      idle_inputs();
      set_req(1, a, b);
      rsp_ready = '1;
      #1;
      n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL rmid_grant got=%b exp=0010", req_ready); end
      step();
      req_valid = '0;
      rst = 1'b1;
      #1;
      n_cmp++; if (rsp_valid !== '0) begin n_bad++; $display("FAIL rmid_calc_valid got=%b exp=0000", rsp_valid); end
      step();
      step();
      rst = 1'b0;
      for (int i = 0; i < N; i++) set_req(i, a, b);
      #1;
      n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL rmid_ptr_reset got=%b exp=0001", req_ready); end
      step();
      req_valid = '0;
      step();
      #1;
      n_cmp++; if (rsp_valid !== 4'b0001) begin n_bad++; $display("FAIL rmid_after_valid got=%b exp=0001", rsp_valid); end
      n_cmp++; if (rsp_sum !== ref_sum(a, b)) begin n_bad++; $display("FAIL rmid_after_sum got=%h exp=%h", rsp_sum, ref_sum(a, b)); end
      step();
      // Reset while a result is being presented.
      set_req(2, a, b);
      rsp_ready = '0;
      step();
      req_valid = '0;
      step();
      #1;
      n_cmp++; if (rsp_valid !== 4'b0100) begin n_bad++; $display("FAIL rmid_resp_valid got=%b exp=0100", rsp_valid); end
      rst = 1'b1;
      #1;
      n_cmp++; if (rsp_valid !== '0) begin n_bad++; $display("FAIL rmid_async_clear got=%b exp=0000", rsp_valid); end
      n_cmp++; if (rsp_sum !== '0) begin n_bad++; $display("FAIL rmid_async_sum got=%h exp=0", rsp_sum); end
      step();
      rst = 1'b0;
      rsp_ready = '1;
      step();
      #1;
      n_cmp++; if (rsp_valid !== '0) begin n_bad++; $display("FAIL rmid_dropped got=%b exp=0000", rsp_valid); end
      step();
   endtask

`ifdef BKA_ARB_STATS_EN
   task automatic test_stats();
      apply_reset();
      #1;
      for (int i = 0; i < N; i++) begin
         n_cmp++; if (grant_cnt[i*CNT_W +: CNT_W] !== '0) begin n_bad++; $display("FAIL stats_reset i=%0d got=%0d exp=0", i, grant_cnt[i*CNT_W +: CNT_W]); end
      end
      rsp_ready = '1;
      for (int op = 0; op < 3; op++) begin
         set_req(2, {$urandom, $urandom}, {$urandom, $urandom});
         step();
         req_valid = '0;
         step();
         step();
      end
      #1;
      for (int i = 0; i < N; i++) begin
         n_cmp++;
         if (grant_cnt[i*CNT_W +: CNT_W] !== CNT_W'(i == 2 ? 3 : 0)) begin
            n_bad++; $display("FAIL stats_count i=%0d got=%0d exp=%0d", i, grant_cnt[i*CNT_W +: CNT_W], (i == 2 ? 3 : 0));
         end
      end
   endtask
`endif

   // Randomized traffic checked against a cycle model: an op accepted in cycle c is
   // presented from c+2 until its owner takes it; the adder is free when nothing is
   // owned or the owner takes its result this cycle.
   task automatic test_random(input int cycles);
      logic         pend[N];
      logic [W-1:0] pa[N];
      logic [W-1:0] pb[N];
      int           cnt[N];
      int           owner, acc_cyc, rr, win, j;
      logic         visible, can_acc;
      logic [N-1:0] exp_rdy, exp_vld;
      apply_reset();
      exp_q.delete();
      owner = -1; acc_cyc = 0; rr = 0;
      for (int i = 0; i < N; i++) begin pend[i] = 1'b0; cnt[i] = 0; pa[i] = '0; pb[i] = '0; end
      for (int c = 0; c < cycles; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
               pend[i] = 1'b1;
               pa[i] = ($urandom_range(0, 7) == 0) ? '1 : {$urandom, $urandom};
               pb[i] = ($urandom_range(0, 7) == 0) ? '1 : {$urandom, $urandom};
            end
            req_valid[i]    = pend[i];
            req_a[i*W +: W] = pa[i];
            req_b[i*W +: W] = pb[i];
         end
         rsp_ready = N'($urandom_range(0, (1 << N) - 1));
         #1;
         visible = (owner >= 0) && (c >= acc_cyc + 2);
         can_acc = (owner < 0) || (visible && rsp_ready[owner]);
         win = -1;
         if (can_acc) begin
            for (int k = 0; k < N; k++) begin
               j = (rr + k) % N;
               if (win < 0 && pend[j]) win = j;
            end
         end
         exp_rdy = '0;
         if (win >= 0) exp_rdy[win] = 1'b1;
         exp_vld = '0;
         if (visible) exp_vld[owner] = 1'b1;
         n_cmp++; if (req_ready !== exp_rdy) begin n_bad++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, req_ready, exp_rdy); end
         n_cmp++; if (rsp_valid !== exp_vld) begin n_bad++; $display("FAIL rand_valid c=%0d got=%b exp=%b", c, rsp_valid, exp_vld); end
         if (visible) begin
            n_cmp++; if (rsp_id !== IW'(owner)) begin n_bad++; $display("FAIL rand_id c=%0d got=%0d exp=%0d", c, rsp_id, owner); end
            n_cmp++; if (rsp_sum !== exp_q[0]) begin n_bad++; $display("FAIL rand_sum c=%0d got=%h exp=%h", c, rsp_sum, exp_q[0]); end
         end
         if (can_acc) begin
            if (visible) void'(exp_q.pop_front());
            owner = win;
            if (win >= 0) begin
               acc_cyc = c;
               exp_q.push_back(ref_sum(pa[win], pb[win]));
               rr = (win + 1) % N;
               pend[win] = 1'b0;
               cnt[win]++;
            end
         end
         step();
      end
      idle_inputs();
      rsp_ready = '1;
      for (int k = 0; k < 4; k++) step();
      #1;
      n_cmp++; if (rsp_valid !== '0) begin n_bad++; $display("FAIL rand_drain got=%b exp=0000", rsp_valid); end
`ifdef BKA_ARB_STATS_EN
      for (int i = 0; i < N; i++) begin
         n_cmp++;
         if (grant_cnt[i*CNT_W +: CNT_W] !== CNT_W'(cnt[i])) begin
            n_bad++; $display("FAIL rand_stats i=%0d got=%0d exp=%0d", i, grant_cnt[i*CNT_W +: CNT_W], cnt[i]);
         end
      end
`endif
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_single();
      test_carry();
      test_fairness();
      test_backpressure();
      test_reset_mid_op();
`ifdef BKA_ARB_STATS_EN
      test_stats();
`endif
      test_random(800);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
